// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
// Serialises A/B transactions, drives memory strobes, returns a 1-cycle ack with captured read data.
module dmem_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req_in,
    input  logic        a_we_in,
    input  logic [31:0] a_addr_in,
    input  logic [31:0] a_wdata_in,
    input  logic [1:0]  a_size_in,
    output logic        a_ack_out,
    output logic [31:0] a_rdata_out,
    input  logic        b_req_in,
    input  logic        b_we_in,
    input  logic [31:0] b_addr_in,
    input  logic [31:0] b_wdata_in,
    input  logic [1:0]  b_size_in,
    output logic        b_ack_out,
    output logic [31:0] b_rdata_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [1:0]  mem_size_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    input  logic [31:0] mem_rdata_in,
    output logic [1:0]  grant_out,
    output logic        busy_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic        we_q;
    logic        last_grant;   // 1 = B was granted last
    logic [1:0]  grant_q;
    logic [31:0] a_rdata_q;
    logic [31:0] b_rdata_q;
    logic        pick_b;

    // On a tie, the port not granted last wins.
    always_comb begin
        pick_b = b_req_in && (!a_req_in || !last_grant);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            we_q          <= 1'b0;
            last_grant    <= 1'b1;
            grant_q       <= 2'b00;
            a_rdata_q     <= 32'd0;
            b_rdata_q     <= 32'd0;
            mem_addr_out  <= 32'd0;
            mem_wdata_out <= 32'd0;
            mem_size_out  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req_in || b_req_in) begin
                        mem_addr_out  <= pick_b ? b_addr_in  : a_addr_in;
                        mem_wdata_out <= pick_b ? b_wdata_in : a_wdata_in;
                        mem_size_out  <= pick_b ? b_size_in  : a_size_in;
                        we_q          <= pick_b ? b_we_in    : a_we_in;
                        last_grant    <= pick_b;
                        grant_q       <= pick_b ? 2'b10 : 2'b01;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= we_q ? DONE : WAIT;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        if (grant_q[1]) b_rdata_q <= mem_rdata_in;
                        else            a_rdata_q <= mem_rdata_in;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    grant_q <= 2'b00;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only; no req-to-output path.
    assign mem_we_out  = (state == ISSUE) &&  we_q;
    assign mem_re_out  = (state == ISSUE) && !we_q;
    assign a_ack_out   = (state == DONE) && grant_q[0];
    assign b_ack_out   = (state == DONE) && grant_q[1];
    assign a_rdata_out = a_rdata_q;
    assign b_rdata_out = b_rdata_q;
    assign grant_out   = grant_q;
    assign busy_out    = (state != IDLE);
endmodule
